// File: rtl/no_grn_node_mc_if.sv
// Handshake/bus bundle for the multi-channel GRN node.
// The transition-count output exists only when NO_GRN_TRANS_CNT_EN is defined.
interface no_grn_node_mc_if #(
    parameter int NUM_CH  = 2,
    parameter int STATE_W = 1,
    parameter int DIV_W   = 4,
    parameter int STAB_W  = 8,
    parameter int TC_W    = 16
);
    logic                              reset_nos;
    logic [STATE_W-1:0]                init_state;
    logic [NUM_CH-1:0]                 start;
    logic [NUM_CH-1:0][DIV_W-1:0]      div_cfg;
    logic [STAB_W-1:0]                 stab_thr;
    logic [NUM_CH-1:0][STATE_W-1:0]    next_in;
    logic [NUM_CH-1:0][STATE_W-1:0]    state;
    logic [NUM_CH-1:0]                 upd_pulse;
    logic [NUM_CH-1:0]                 changed;
    logic [NUM_CH-1:0]                 stable;
`ifdef NO_GRN_TRANS_CNT_EN
    logic [NUM_CH-1:0][TC_W-1:0]       trans_cnt;

    modport master (
        output reset_nos, init_state, start, div_cfg, stab_thr, next_in,
        input  state, upd_pulse, changed, stable, trans_cnt
    );
    modport slave (
        input  reset_nos, init_state, start, div_cfg, stab_thr, next_in,
        output state, upd_pulse, changed, stable, trans_cnt
    );
`else
    modport master (
        output reset_nos, init_state, start, div_cfg, stab_thr, next_in,
        input  state, upd_pulse, changed, stable
    );
    modport slave (
        input  reset_nos, init_state, start, div_cfg, stab_thr, next_in,
        output state, upd_pulse, changed, stable
    );
`endif
endinterface

// File: rtl/no_grn_node_mc.sv
// Multi-channel GRN node: per-channel state slot with divided update strobe,
// change flag and stability detector. NO_GRN_TRANS_CNT_EN adds a transition counter.
module no_grn_node_mc_ch #(
    parameter int STATE_W = 1,
    parameter int DIV_W   = 4,
    parameter int STAB_W  = 8,
    parameter int TC_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reset_nos_i,
    input  logic [STATE_W-1:0] init_state_i,
    input  logic               start_i,
    input  logic [DIV_W-1:0]   div_cfg_i,
    input  logic [STAB_W-1:0]  stab_thr_i,
    input  logic [STATE_W-1:0] next_in_i,
`ifdef NO_GRN_TRANS_CNT_EN
    output logic [TC_W-1:0]    trans_cnt_o,
`endif
    output logic [STATE_W-1:0] state_o,
    output logic               upd_pulse_o,
    output logic               changed_o,
    output logic               stable_o
);
    logic [STATE_W-1:0] state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic               upd_q, upd_d;
    logic               chg_q, chg_d;
    logic               diff;
`ifdef NO_GRN_TRANS_CNT_EN
    logic [TC_W-1:0]    tc_q, tc_d;
`endif

    assign diff = (next_in_i != state_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stab_d  = stab_q;
        chg_d   = chg_q;
        upd_d   = 1'b0;
`ifdef NO_GRN_TRANS_CNT_EN
        tc_d    = tc_q;
`endif
        if (reset_nos_i) begin
            state_d = init_state_i;
            cnt_d   = '0;
            stab_d  = '0;
            chg_d   = 1'b0;
`ifdef NO_GRN_TRANS_CNT_EN
            tc_d    = '0;
`endif
        end else if (start_i) begin
            if (cnt_q == '0) begin
                // Reload from the live div_cfg; a mid-count change only lands here.
                state_d = next_in_i;
                cnt_d   = div_cfg_i;
                upd_d   = 1'b1;
                chg_d   = diff;
                if (diff) begin
                    stab_d = '0;
`ifdef NO_GRN_TRANS_CNT_EN
                    tc_d   = (&tc_q) ? tc_q : tc_q + 1'b1;
`endif
                end else begin
                    stab_d = (&stab_q) ? stab_q : stab_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            cnt_q   <= '0;
            stab_q  <= '0;
            upd_q   <= 1'b0;
            chg_q   <= 1'b0;
`ifdef NO_GRN_TRANS_CNT_EN
            tc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stab_q  <= stab_d;
            upd_q   <= upd_d;
            chg_q   <= chg_d;
`ifdef NO_GRN_TRANS_CNT_EN
            tc_q    <= tc_d;
`endif
        end
    end

    assign state_o     = state_q;
    assign upd_pulse_o = upd_q;
    assign changed_o   = chg_q;
    // Threshold is compared live so the controller can retune it on the fly.
    assign stable_o    = (stab_thr_i != '0) && (stab_q >= stab_thr_i);
`ifdef NO_GRN_TRANS_CNT_EN
    assign trans_cnt_o = tc_q;
`endif
endmodule

module no_grn_node_mc #(
    parameter int NUM_CH  = 2,
    parameter int STATE_W = 1,
    parameter int DIV_W   = 4,
    parameter int STAB_W  = 8,
    parameter int TC_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    no_grn_node_mc_if.slave bus
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        no_grn_node_mc_ch #(
            .STATE_W (STATE_W),
            .DIV_W   (DIV_W),
            .STAB_W  (STAB_W),
            .TC_W    (TC_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .reset_nos_i  (bus.reset_nos),
            .init_state_i (bus.init_state),
            .start_i      (bus.start[c]),
            .div_cfg_i    (bus.div_cfg[c]),
            .stab_thr_i   (bus.stab_thr),
            .next_in_i    (bus.next_in[c]),
`ifdef NO_GRN_TRANS_CNT_EN
            .trans_cnt_o  (bus.trans_cnt[c]),
`endif
            .state_o      (bus.state[c]),
            .upd_pulse_o  (bus.upd_pulse[c]),
            .changed_o    (bus.changed[c]),
            .stable_o     (bus.stable[c])
        );
    end
endmodule

// File: tb/tb_no_grn_node_mc.sv
// Scoreboard bench for no_grn_node_mc: directed steps push hand-computed
// expectations, a monitor pops and compares one record per stimulus edge.
module tb_no_grn_node_mc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    no_grn_node_mc_if #(.NUM_CH(2), .STATE_W(1), .DIV_W(4), .STAB_W(2), .TC_W(2)) bus ();

    no_grn_node_mc #(.NUM_CH(2), .STATE_W(1), .DIV_W(4), .STAB_W(2), .TC_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      nm;
        logic [1:0] st;
        logic [1:0] up;
        logic [1:0] ch;
        logic [1:0] sb;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got st/up/ch/sb=%b expected %b", nm, act, expv);
        end
    endtask

    // Monitor: after each active edge, compare against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.nm, {bus.state, bus.upd_pulse, bus.changed, bus.stable},
                {e.st, e.up, e.ch, e.sb});
        end
    end

    // One strobe cycle followed by an idle cycle; bits are {ch1, ch0}.
    task automatic step(input string nm, input logic rn, input logic init,
                        input logic [1:0] strt, input logic [1:0] nxt,
                        input logic [1:0] est, input logic [1:0] eup,
                        input logic [1:0] ech, input logic [1:0] esb);
        exp_t e;
        @(negedge clk);
        bus.reset_nos  = rn;
        bus.init_state = init;
        bus.start      = strt;
        bus.next_in    = nxt;
        e.nm = nm; e.st = est; e.up = eup; e.ch = ech; e.sb = esb;
        q.push_back(e);
        @(negedge clk);
        bus.reset_nos = 1'b0;
        bus.start     = 2'b00;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        bus.reset_nos  = 1'b0;
        bus.init_state = 1'b0;
        bus.start      = 2'b00;
        bus.div_cfg    = {4'd0, 4'd0};
        bus.stab_thr   = 2'd0;
        bus.next_in    = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_state", {bus.state, bus.upd_pulse, bus.changed, bus.stable}, 8'h00);
        rst = 1'b1;

        // Basic commit, then async reset mid-run with start active
        step("a_commit", 0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00);
        step("a_hold",   0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00);
        drain();
        @(negedge clk);
        bus.start   = 2'b11;
        bus.next_in = 2'b00;
        #2 rst = 1'b0;
        #1 chk("async_rst", {bus.state, bus.upd_pulse, bus.changed, bus.stable}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        bus.start = 2'b00;
        step("rst_first", 0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00);

        // Divider: ch0 div=1, ch1 div=0
        bus.div_cfg = {4'd0, 4'd1};
        step("b_nos", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step("b_s1",  0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00);
        step("b_s2",  0, 0, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00);
        step("b_s3",  0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
        step("b_s4",  0, 0, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00);

        // Priority: reset_nos beats start; cnt cleared so next strobe commits
        bus.div_cfg = {4'd0, 4'd0};
        step("c_prio",  1, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        step("c_after", 0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);

        // Stability with threshold 3
        bus.stab_thr = 2'd3;
        step("d_nos", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step("d_u1",  0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        step("d_u2",  0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        step("d_u3",  0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
        step("d_idle",0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
        step("d_chg", 0, 0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10);
        drain();
        bus.stab_thr = 2'd0;
        step("d_thr0", 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
        drain();
        bus.stab_thr = 2'd3;
        step("e_sat1", 0, 0, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10);
        for (int i = 0; i < 5; i++)
            step($sformatf("e_sat0_%0d", i), 0, 0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                 (i >= 2) ? 2'b11 : 2'b10);

        // Mid-count divider change
        drain();
        bus.stab_thr = 2'd0;
        bus.div_cfg  = {4'd3, 4'd3};
        step("f_nos", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step("f_c1",  0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00);
        drain();
        bus.div_cfg = {4'd0, 4'd0};
        for (int i = 0; i < 3; i++)
            step($sformatf("f_skip%0d", i), 0, 0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00);
        step("f_c2", 0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
        step("f_c3", 0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00);
        step("f_c4", 0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);

        // Five toggling commits on ch0 only
        step("g_nos", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++)
            step($sformatf("g_tog%0d", i), 0, 0, 2'b01, (i % 2 == 0) ? 2'b01 : 2'b00,
                 (i % 2 == 0) ? 2'b01 : 2'b00, 2'b01, 2'b01, 2'b00);
        drain();
`ifdef NO_GRN_TRANS_CNT_EN
        n_tests++;
        if (bus.trans_cnt !== 4'b0011) begin
            n_fail++;
            $display("FAIL trans_cnt_sat: got %b expected %b", bus.trans_cnt, 4'b0011);
        end
        step("g_nos2", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        drain();
        n_tests++;
        if (bus.trans_cnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL trans_cnt_clr: got %b expected %b", bus.trans_cnt, 4'b0000);
        end
`endif
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
